// File: rtl/obc_chk_pkg.sv
// rtl/obc_chk_pkg.sv - shared types, LFSR taps and local answer function for the OBC challenge monitor
package obc_chk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ANS,
        VALID,
        SHUTDOWN
    } obc_state_e;

    localparam logic [15:0] LFSR_TAPS   = 16'hB400;
    localparam int          MAX_Q_WIDTH = 64;

    // Bit i of the answer depends only on bits i and i-1, so callers may zero-extend
    // narrower questions and truncate the result.
    function automatic logic [MAX_Q_WIDTH-1:0] local_answer(input logic [MAX_Q_WIDTH-1:0] q);
        logic [MAX_Q_WIDTH-1:0] r;
        r[0] = ~q[0];
        for (int i = 1; i < MAX_Q_WIDTH; i++) begin
            r[i] = q[i-1] ^ q[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/obc_challenge_monitor_if.sv
// rtl/obc_challenge_monitor_if.sv - question/answer handshake between monitor and OBC
interface obc_challenge_monitor_if #(
    parameter int Q_WIDTH = 4
);
    logic               q_valid;
    logic               q_ready;
    logic [Q_WIDTH-1:0] question;
    logic               ans_valid;
    logic [Q_WIDTH-1:0] answer_obc;

    modport master (
        output q_valid,
        output question,
        input  q_ready,
        input  ans_valid,
        input  answer_obc
    );

    modport slave (
        input  q_valid,
        input  question,
        output q_ready,
        output ans_valid,
        output answer_obc
    );
endinterface

// File: rtl/challenge_lfsr.sv
// rtl/challenge_lfsr.sv - 16-bit Galois LFSR question source, advances once per strobe
module challenge_lfsr
    import obc_chk_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    output logic [15:0] state
);
    // An all-zero state would lock the LFSR, so a zero seed is promoted to 1.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= SEED_EFF;
        end else if (advance) begin
            state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
        end
    end
endmodule

// File: rtl/obc_challenge_monitor.sv
// rtl/obc_challenge_monitor.sv - OBC challenge/response watchdog: FSM, timer, round/fail counters, comparator
module obc_challenge_monitor
    import obc_chk_pkg::*;
#(
    parameter int          Q_WIDTH     = 4,
    parameter int          N_ROUNDS    = 10,
    parameter int          MAX_FAILS   = 2,
    parameter int          TIMEOUT_CYC = 255,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    obc_challenge_monitor_if.master        bus,
    output logic                           busy,
    output logic                           pass,
    output logic                           override,
    output logic                           obc_reset,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_count
);
    localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
    localparam int ROUND_W = $clog2(N_ROUNDS + 1);
    localparam int TMR_W   = $clog2(TIMEOUT_CYC + 1);
    localparam int REP     = (Q_WIDTH + 15) / 16;

    localparam logic [FAIL_W-1:0]  FAIL_LIMIT  = FAIL_W'(MAX_FAILS);
    localparam logic [ROUND_W-1:0] ROUND_LIMIT = ROUND_W'(N_ROUNDS);
    localparam logic [TMR_W-1:0]   TMR_LAST    = TMR_W'(TIMEOUT_CYC - 1);

    obc_state_e             state_q, state_d;
    logic [ROUND_W-1:0]     round_q, round_d;
    logic [FAIL_W-1:0]      fail_q, fail_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [Q_WIDTH-1:0]     qlat_q, qlat_d;
    logic                   obc_reset_q;
    logic                   advance, round_end, round_fail, q_valid;
    logic [15:0]            lfsr_state;
    logic [REP*16-1:0]      lfsr_rep;
    logic [Q_WIDTH-1:0]     cur_question, exp_ans;
    logic [MAX_Q_WIDTH-1:0] exp_full;
    logic                   unused_bits;

    challenge_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (advance),
        .state   (lfsr_state)
    );

    assign lfsr_rep     = {REP{lfsr_state}};
    assign cur_question = lfsr_rep[Q_WIDTH-1:0];
    assign exp_full     = local_answer(MAX_Q_WIDTH'(qlat_q));
    assign exp_ans      = exp_full[Q_WIDTH-1:0];
    assign unused_bits  = ^{lfsr_rep, exp_full};

    always_comb begin
        state_d    = state_q;
        round_d    = round_q;
        fail_d     = fail_q;
        timer_d    = timer_q;
        qlat_d     = qlat_q;
        advance    = 1'b0;
        round_end  = 1'b0;
        round_fail = 1'b0;
        case (state_q)
            IDLE, VALID: begin
                if (start) begin
                    round_d = '0;
                    fail_d  = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.q_ready) begin
                    advance = 1'b1;
                    qlat_d  = cur_question;
                    timer_d = '0;
                    state_d = WAIT_ANS;
                end
            end
            WAIT_ANS: begin
                // An answer arriving on the last allowed cycle wins over the timeout.
                if (bus.ans_valid) begin
                    round_end  = 1'b1;
                    round_fail = (bus.answer_obc != exp_ans);
                end else if (timer_q == TMR_LAST) begin
                    round_end  = 1'b1;
                    round_fail = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
                if (round_end) begin
                    if (round_fail && fail_q != FAIL_LIMIT) fail_d = fail_q + 1'b1;
                    if (round_q != ROUND_LIMIT) round_d = round_q + 1'b1;
                    if (fail_d == FAIL_LIMIT) state_d = SHUTDOWN;
                    else if (round_d == ROUND_LIMIT) state_d = VALID;
                    else state_d = ISSUE;
                end
            end
            SHUTDOWN: state_d = SHUTDOWN;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            round_q     <= '0;
            fail_q      <= '0;
            timer_q     <= '0;
            qlat_q      <= '0;
            obc_reset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            fail_q      <= fail_d;
            timer_q     <= timer_d;
            qlat_q      <= qlat_d;
            obc_reset_q <= (state_d == SHUTDOWN) && (state_q != SHUTDOWN);
        end
    end

    assign q_valid      = (state_q == ISSUE);
    assign bus.q_valid  = q_valid;
    assign bus.question = q_valid ? cur_question : '0;
    assign busy         = (state_q == ISSUE) || (state_q == WAIT_ANS);
    assign pass         = (state_q == VALID);
    assign override     = (state_q == SHUTDOWN);
    assign obc_reset    = obc_reset_q;
    assign fail_count   = fail_q;
endmodule

// File: tb/tb_obc_challenge_monitor.sv
// tb/tb_obc_challenge_monitor.sv - randomized self-checking bench for obc_challenge_monitor
module tb_obc_challenge_monitor;
    import obc_chk_pkg::*;

    localparam int          QW   = 4;
    localparam int          NR   = 10;
    localparam int          MF   = 2;
    localparam int          TO   = 255;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       busy, pass, override, obc_reset;
    logic [1:0] fail_count;

    obc_challenge_monitor_if #(.Q_WIDTH(QW)) bus ();

    obc_challenge_monitor #(
        .Q_WIDTH(QW), .N_ROUNDS(NR), .MAX_FAILS(MF), .TIMEOUT_CYC(TO), .LFSR_SEED(SEED)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .pass       (pass),
        .override   (override),
        .obc_reset  (obc_reset),
        .fail_count (fail_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] m_lfsr;
    int          m_fails, m_rounds;
    logic        m_shut, m_valid;
    int          plan [NR];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic logic [QW-1:0] model_answer(input logic [QW-1:0] q);
        logic [QW-1:0] r;
        r    = q ^ (q << 1);
        r[0] = ~q[0];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0;
        bus.q_ready = 1'b0;
        bus.ans_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        m_lfsr = SEED;
        m_fails = 0;
        m_rounds = 0;
        m_shut = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic start_session();
        start = 1'b1;
        step();
        start = 1'b0;
        m_fails = 0;
        m_rounds = 0;
        m_valid = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_pass_clear", 32'(pass), 32'd0);
        check("start_fail_clear", 32'(fail_count), 32'd0);
    endtask

    // kind: 0 correct answer, 1 wrong answer, 2 timeout; ans_dly is the WAIT_ANS cycle (1-based)
    task automatic do_round(input int kind, input int ready_dly, input int ans_dly);
        logic [QW-1:0] q;
        logic          eb;
        int            w;
        w = 0;
        while (!bus.q_valid && w < 8) begin
            step();
            w++;
        end
        check("q_valid", 32'(bus.q_valid), 32'd1);
        q = m_lfsr[QW-1:0];
        check("question", 32'(bus.question), 32'(q));
        repeat (ready_dly) step();
        bus.q_ready = 1'b1;
        step();
        bus.q_ready = 1'b0;
        m_lfsr = lfsr_next(m_lfsr);
        check("wait_ans_entry", 32'({bus.q_valid, busy}), 32'b01);
        if (kind == 2) begin
            repeat (TO - 1) step();
            check("pre_timeout_busy", 32'(busy), 32'd1);
            check("pre_timeout_fails", 32'(fail_count), 32'(m_fails));
            step();
        end else begin
            repeat (ans_dly - 1) step();
            bus.ans_valid = 1'b1;
            bus.answer_obc = (kind == 0) ? model_answer(q)
                                         : model_answer(q) ^ QW'($urandom_range(1, (1 << QW) - 1));
            step();
            bus.ans_valid = 1'b0;
        end
        m_rounds++;
        if (kind != 0) m_fails++;
        if (m_fails == MF) m_shut = 1'b1;
        else if (m_rounds == NR) m_valid = 1'b1;
        eb = !(m_shut || m_valid);
        check("round_fail_count", 32'(fail_count), 32'(m_fails));
        check("round_override", 32'(override), 32'(m_shut));
        check("round_obc_reset", 32'(obc_reset), 32'(m_shut));
        check("round_pass", 32'(pass), 32'(m_valid));
        check("round_busy", 32'(busy), 32'(eb));
        if (m_shut) begin
            step();
            check("obc_reset_one_cycle", 32'(obc_reset), 32'd0);
            check("override_sticky", 32'(override), 32'd1);
        end
    endtask

    task automatic run_session();
        for (int r = 0; r < NR; r++) begin
            if (!m_shut && !m_valid) do_round(plan[r], $urandom_range(0, 3), $urandom_range(1, 20));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, 32'({bus.q_valid, bus.question, busy, pass, override, obc_reset, fail_count}), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0]   la;
        logic [QW-1:0] q0;
        logic          stable;
        int            r;
        bus.q_ready = 1'b0;
        bus.ans_valid = 1'b0;
        bus.answer_obc = '0;

        la = local_answer(64'h6);
        check("pkg_local_answer_0110", 32'(la[3:0]), 32'hB);

        do_reset();
        check_reset_outputs("reset_outputs");

        // All rounds answered correctly
        start_session();
        plan = '{default: 0};
        run_session();
        check("all_ok_pass", 32'(pass), 32'd1);
        check("all_ok_fails", 32'(fail_count), 32'd0);
        check("all_ok_override", 32'(override), 32'd0);

        // One wrong answer in round 3, restarted from VALID
        start_session();
        plan = '{default: 0};
        plan[2] = 1;
        run_session();
        check("one_wrong_pass", 32'(pass), 32'd1);
        check("one_wrong_fails", 32'(fail_count), 32'd1);

        // q_ready held low: question must hold, stray ans_valid ignored
        start_session();
        q0 = bus.question;
        stable = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            bus.ans_valid = (i == 500);
            bus.answer_obc = ~model_answer(q0);
            step();
            if (bus.question !== q0 || bus.q_valid !== 1'b1 || fail_count !== 2'd0) stable = 1'b0;
        end
        bus.ans_valid = 1'b0;
        check("issue_hold_stable", 32'(stable), 32'd1);
        check("issue_hold_no_fail", 32'(fail_count), 32'd0);
        while (!m_shut && !m_valid) begin
            r = $urandom_range(0, 19);
            do_round((r == 0) ? 2 : ((r < 3) ? 1 : 0), $urandom_range(0, 5), $urandom_range(1, TO));
        end

        // Reset during WAIT_ANS of round 4
        do_reset();
        start_session();
        plan = '{default: 0};
        for (int i = 0; i < 3; i++) do_round(0, $urandom_range(0, 2), $urandom_range(1, 10));
        bus.q_ready = 1'b1;
        step();
        bus.q_ready = 1'b0;
        repeat (5) step();
        check("r4_waiting", 32'({bus.q_valid, busy}), 32'b01);
        reset = 1'b0;
        step();
        check_reset_outputs("mid_session_reset_outputs");
        reset = 1'b1;
        m_lfsr = SEED;
        m_shut = 1'b0;
        start_session();
        check("seed_question_after_reset", 32'(bus.question), 32'h1);
        do_round(0, 1, 3);

        // Wrong answers in rounds 2 and 5 -> shutdown, start ignored
        do_reset();
        start_session();
        plan = '{default: 0};
        plan[1] = 1;
        plan[4] = 1;
        run_session();
        check("shutdown_rounds", m_rounds, 5);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("shutdown_start_ignored", 32'({bus.q_valid, busy, pass}), 32'd0);
        check("shutdown_override_held", 32'(override), 32'd1);

        // Two timeouts, with an answer on the last allowed cycle in between
        do_reset();
        start_session();
        do_round(2, 0, 1);
        do_round(0, 0, TO);
        check("last_cycle_answer_counts", 32'(fail_count), 32'd1);
        do_round(2, 1, 1);
        check("timeout_shutdown", 32'(override), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
